// File: rtl/rd_skew_ctrl_if.sv
// Handshake and read-bus bundle between the array controller and rd_skew_ctrl.
// master = controller side, slave = address generator side.
interface rd_skew_ctrl_if #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
);
   logic                      start;
   logic [ADDR_W-1:0]         base_addr;
   logic [LEN_W-1:0]          num_rows;
   logic                      busy;
   logic                      done;
   logic [LANES-1:0]          rd_en;
   logic [LANES*ADDR_W-1:0]   rd_addr;

   modport master (
      output start, base_addr, num_rows,
      input  busy, done, rd_en, rd_addr
   );

   modport slave (
      input  start, base_addr, num_rows,
      output busy, done, rd_en, rd_addr
   );
endinterface

// File: rtl/rd_skew_ctrl.sv
// Skewed read-address/enable generator: lane i trails lane i-1 by one cycle, NUM rows from BASE.
// Optional RD_SKEW_STALL_EN adds a stall input that freezes an active run.
module rd_skew_ctrl #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic clk,
   input  logic reset,
`ifdef RD_SKEW_STALL_EN
   input  logic stall,
`endif
   rd_skew_ctrl_if.slave bus
);

   localparam int T_W = LEN_W + $clog2(LANES) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state, state_nxt;
   logic [T_W-1:0]            t, t_nxt;
   logic [ADDR_W-1:0]         base_q, base_nxt;
   logic [LEN_W-1:0]          num_q, num_nxt;
   logic                      busy_q, busy_nxt;
   logic                      done_q, done_nxt;
   logic [LANES-1:0]          en_q, en_nxt;
   logic [LANES*ADDR_W-1:0]   addr_q, addr_nxt;
   logic                      hold, accept, last;

`ifdef RD_SKEW_STALL_EN
   assign hold = (state == RUN) && stall;
`else
   assign hold = 1'b0;
`endif

   assign accept = (state == IDLE) && bus.start && (bus.num_rows != '0);
   // Final step of a run is t = num_rows + LANES - 2 (num_rows >= 1 here).
   assign last   = (t == T_W'(num_q) + T_W'(LANES) - T_W'(2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         t      <= '0;
         base_q <= '0;
         num_q  <= '0;
      end else begin
         state  <= state_nxt;
         t      <= t_nxt;
         base_q <= base_nxt;
         num_q  <= num_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      t_nxt     = t;
      base_nxt  = base_q;
      num_nxt   = num_q;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = RUN;
               t_nxt     = '0;
               base_nxt  = bus.base_addr;
               num_nxt   = bus.num_rows;
            end else if (bus.start) begin
               state_nxt = DONE;
            end
         end
         RUN: begin
            if (!hold) begin
               if (last) state_nxt = DONE;
               else      t_nxt     = t + T_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are computed from the next step so that they come straight off flops.
   always_comb begin
      busy_nxt = (state_nxt == RUN);
      done_nxt = (state_nxt == DONE);
      en_nxt   = '0;
      addr_nxt = addr_q;
      if (state_nxt == RUN) begin
         for (int i = 0; i < LANES; i++) begin
            en_nxt[i] = (t_nxt >= T_W'(i)) && (t_nxt < T_W'(i) + T_W'(num_nxt));
            if (accept)
               addr_nxt[i*ADDR_W +: ADDR_W] = base_nxt;
            if (en_nxt[i])
               addr_nxt[i*ADDR_W +: ADDR_W] = base_nxt + ADDR_W'(t_nxt - T_W'(i));
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         en_q   <= '0;
         addr_q <= '0;
      end else begin
         busy_q <= busy_nxt;
         done_q <= done_nxt;
         en_q   <= en_nxt;
         addr_q <= addr_nxt;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rd_en   = en_q;
   assign bus.rd_addr = addr_q;

endmodule

// File: tb/tb_rd_skew_ctrl.sv
// Bench for rd_skew_ctrl with 4-, 1- and 8-lane instances against a per-cycle behavioural model.
// Stall coverage is enabled when RD_SKEW_STALL_EN is defined.
module tb_rd_skew_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b0;
`ifdef RD_SKEW_STALL_EN
   logic stall = 1'b0;
`endif

   always #5 clk = ~clk;

   rd_skew_ctrl_if #(.LANES(4), .ADDR_W(8), .LEN_W(8)) if4 ();
   rd_skew_ctrl_if #(.LANES(1), .ADDR_W(8), .LEN_W(8)) if1 ();
   rd_skew_ctrl_if #(.LANES(8), .ADDR_W(8), .LEN_W(8)) if8 ();

   rd_skew_ctrl #(.LANES(4), .ADDR_W(8), .LEN_W(8)) u4 (
      .clk(clk), .reset(reset),
`ifdef RD_SKEW_STALL_EN
      .stall(stall),
`endif
      .bus(if4));
   rd_skew_ctrl #(.LANES(1), .ADDR_W(8), .LEN_W(8)) u1 (
      .clk(clk), .reset(reset),
`ifdef RD_SKEW_STALL_EN
      .stall(1'b0),
`endif
      .bus(if1));
   rd_skew_ctrl #(.LANES(8), .ADDR_W(8), .LEN_W(8)) u8 (
      .clk(clk), .reset(reset),
`ifdef RD_SKEW_STALL_EN
      .stall(1'b0),
`endif
      .bus(if8));

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] maddr [3][8];

   function automatic int lanes_of(input int d);
      return (d == 0) ? 4 : (d == 1) ? 1 : 8;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic s, input logic [7:0] b, input logic [7:0] n);
      case (d)
         0:       begin if4.start = s; if4.base_addr = b; if4.num_rows = n; end
         1:       begin if1.start = s; if1.base_addr = b; if1.num_rows = n; end
         default: begin if8.start = s; if8.base_addr = b; if8.num_rows = n; end
      endcase
   endtask

   task automatic sample(input int d, output logic bz, output logic dn,
                         output logic [7:0] en, output logic [63:0] ad);
      case (d)
         0:       begin bz = if4.busy; dn = if4.done; en = 8'(if4.rd_en); ad = 64'(if4.rd_addr); end
         1:       begin bz = if1.busy; dn = if1.done; en = 8'(if1.rd_en); ad = 64'(if1.rd_addr); end
         default: begin bz = if8.busy; dn = if8.done; en = 8'(if8.rd_en); ad = 64'(if8.rd_addr); end
      endcase
   endtask

   task automatic check_outputs(input int d, input string tag,
                                input logic eb, input logic ed, input logic [7:0] een);
      logic        bz, dn;
      logic [7:0]  en;
      logic [63:0] ad, ead;
      sample(d, bz, dn, en, ad);
      ead = '0;
      for (int i = 0; i < lanes_of(d); i++) ead[i*8 +: 8] = maddr[d][i];
      check({tag, ".busy"},    64'(bz), 64'(eb));
      check({tag, ".done"},    64'(dn), 64'(ed));
      check({tag, ".rd_en"},   64'(en), 64'(een));
      check({tag, ".rd_addr"}, ad,      ead);
   endtask

   // One run on instance d, starting at posedge+1. Stall is held over cycles slo..shi,
   // a second start (base 0x40) is pulsed at cycle ign_k. Ends after one idle cycle.
   task automatic run(input int d, input string tag, input logic [7:0] base, input logic [7:0] num,
                      input int slo, input int shi, input int ign_k);
      int   L     = lanes_of(d);
      int   nrun  = (num == 0) ? 0 : int'(num) + L - 1;
      int   t     = 0;
      int   k     = 0;
      bit   in_run = (num != 0);
      bit   pend   = (num == 0);
      bit   fin    = 1'b0;
      bit   stall_k;
      logic eb, ed;
      logic [7:0] een;
      drive(d, 1'b1, base, num);
      while (!fin) begin
         @(posedge clk);
         #1;
         k++;
         if (k == 1)         drive(d, 1'b0, base, num);
         if (k == ign_k)     drive(d, 1'b1, 8'h40, num);
         if (k == ign_k + 1) drive(d, 1'b0, 8'h40, num);
         eb = 1'b0; ed = 1'b0; een = '0;
         if (in_run) begin
            eb = 1'b1;
            for (int i = 0; i < L; i++) begin
               int tt = t - i;
               een[i] = (t >= i) && (t < i + int'(num));
               if (tt < 0)            tt = 0;
               if (tt > int'(num) - 1) tt = int'(num) - 1;
               maddr[d][i] = 8'(int'(base) + tt);
            end
         end else if (pend) begin
            ed = 1'b1;
         end else begin
            fin = 1'b1;
         end
         check_outputs(d, $sformatf("%s.c%0d", tag, k), eb, ed, een);
         stall_k = (d == 0) && (k >= slo) && (k <= shi) && in_run;
`ifdef RD_SKEW_STALL_EN
         stall = stall_k;
`endif
         if (in_run) begin
            if (!stall_k) begin
               if (t == nrun - 1) begin in_run = 1'b0; pend = 1'b1; end
               else t++;
            end
         end else if (pend) begin
            pend = 1'b0;
         end
      end
`ifdef RD_SKEW_STALL_EN
      stall = 1'b0;
`endif
   endtask

   initial begin
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 8; i++) maddr[d][i] = 8'h00;
      for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 8'h00);

      #12;
      for (int d = 0; d < 3; d++) check_outputs(d, $sformatf("reset.d%0d", d), 1'b0, 1'b0, 8'h00);
      reset = 1'b1;
      @(posedge clk);
      #1;

      run(0, "basic",  8'h10, 8'd3, 0, 0, 0);
      run(0, "zero",   8'h22, 8'd0, 0, 0, 0);
      run(0, "wrap",   8'hFE, 8'd4, 0, 0, 0);
      run(0, "ignore", 8'h10, 8'd3, 0, 0, 2);
      run(1, "l1",     8'h33, 8'd1, 0, 0, 0);
      run(2, "l8",     8'h80, 8'd1, 0, 0, 0);
`ifdef RD_SKEW_STALL_EN
      run(0, "stall",  8'h10, 8'd3, 3, 4, 0);
`endif

      // Abort mid-run: reset must clear outputs without a clock edge.
      drive(0, 1'b1, 8'h10, 8'd3);
      @(posedge clk); #1; drive(0, 1'b0, 8'h10, 8'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 8; i++) maddr[d][i] = 8'h00;
      check_outputs(0, "abort", 1'b0, 1'b0, 8'h00);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run(0, "after_abort", 8'h10, 8'd3, 0, 0, 0);

      for (int r = 0; r < 12; r++) begin
         int         d   = r % 3;
         logic [7:0] b   = 8'($urandom);
         logic [7:0] n   = 8'($urandom_range(0, 10));
         int         slo = 0;
         int         shi = 0;
`ifdef RD_SKEW_STALL_EN
         if (d == 0) begin
            slo = $urandom_range(1, 8);
            shi = slo + $urandom_range(0, 2);
         end
`endif
         run(d, $sformatf("rand%0d", r), b, n, slo, shi, (r % 4 == 1) ? 3 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
